sig_subtractor_seq: RTL and testbench
=====================================

// Module: sig_subtractor_seq
// PURPOSE
//  Multi-cycle unsigned subtractor for extended significands (W = sigWidth+low_expand+4 bits).
//  Computes a-b as a + ~b + 1, CHUNK bits per cycle, with a ripple-borrow chain.
//  Produces two's-complement diff, borrow, |a-b| and a zero flag.
//  Serves the effective-subtraction path of the GEMM/FFT FP adder, complementing the ripple adder.
// PARAMETERS
//  sigWidth    4  significand width without hidden/guard bits
//  low_expand  2  extra low-order guard bits
//  CHUNK       2  bits processed per cycle (1..W); NCHUNK = ceil(W/CHUNK); default W=10, NCHUNK=5
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operands a,b valid
//  in_ready   out  1  block can accept operands
//  a          in   W  minuend, unsigned
//  b          in   W  subtrahend, unsigned
//  out_valid  out  1  result valid, held until accepted
//  out_ready  in   1  consumer accepts result
//  diff       out  W  (a-b) mod 2^W
//  mag        out  W  |a-b|
//  borrow     out  1  1 when a<b
//  zero       out  1  1 when a==b
// BEHAVIOUR
//  - States: IDLE, SUB, NEG, DONE. Reset -> IDLE; out_valid/diff/mag/borrow/zero = 0.
//  - in_ready = (state==IDLE) && !rst. Operands are captured on in_valid&&in_ready (cycle T).
//  - IDLE->SUB on capture. carry_in=1. Chunk k (LSB first) is processed in cycle T+1+k.
//    For chunk k: diff chunk = a_k + ~b_k + carry; carry is registered between chunks.
//  - If W is not a multiple of CHUNK, the top chunk is zero-padded. Pad bits are forced to
//    behave as a=0, b=0 (their ~b is not used). Carry is taken from bit W-1, not from the pad.
//  - After the last chunk: borrow = ~carry_out. zero = (diff==0), accumulated per chunk.
//  - borrow=0: mag=diff, go to DONE. out_valid=1 from cycle T+NCHUNK+1.
//  - borrow=1: go to NEG. mag = ~diff + 1, chunkwise over NCHUNK cycles, same chain,
//    carry_in=1. Then DONE; out_valid=1 from cycle T+2*NCHUNK+1.
//  - DONE: all outputs stay stable while out_ready=0.
//    On out_valid&&out_ready: -> IDLE, out_valid=0 next cycle. in_ready is 1 that cycle.
//    No overlap between input and output transactions.
//  - Operand changes on a/b outside the capture cycle are ignored.
//  - rst in any state (mid-SUB/NEG/DONE) aborts the operation within 1 cycle: outputs cleared,
//    no partial result emitted.
//  - Edge cases: a==b gives diff=0, mag=0, borrow=0, zero=1. a=0,b=2^W-1 gives mag=2^W-1
//    with no overflow, since |a-b| < 2^W always.
// STRUCTURE
//  - Shared package/include: W, NCHUNK, state encoding (IDLE=0,SUB=1,NEG=2,DONE=3), chunk index width.
//  - One sub-module sub_chunk: CHUNK-bit ripple of adder_1bit cells (a, b_eff, cin -> s, cout).
//    b_eff = ~b in SUB; in NEG, a := ~diff and b_eff := 0.
//  - Top level holds FSM, chunk counter, operand/result shift registers, carry flop.
// TESTING (W=10, CHUNK=2)
//  1. a=0x2A5, b=0x0F3 -> diff=0x1B2, mag=0x1B2, borrow=0, zero=0; out_valid at T+6.
//  2. a=0x005, b=0x009 -> diff=0x3FC, mag=0x004, borrow=1; out_valid at T+11.
//  3. a=b=0x3FF -> diff=0, mag=0, borrow=0, zero=1. Then a=0, b=0x3FF -> diff=0x001, mag=0x3FF, borrow=1.
//  4. Backpressure: out_ready=0 for 7 cycles in DONE -> outputs stable, in_ready=0.
//     New in_valid is ignored. Accept -> in_ready=1 next cycle.
//  5. rst asserted at T+3 of a borrow=1 op -> next cycle state IDLE, all outputs 0, no out_valid.
//  6. CHUNK=3 (padded top chunk): 2000 random a,b vs golden a-b -> diff/mag/borrow/zero match;
//     latency = NCHUNK+1 or 2*NCHUNK+1.

Source files
------------

// File: rtl/sig_subtractor_seq_pkg.sv
// Shared constants and state encoding for the multi-cycle significand subtractor.
package sig_subtractor_seq_pkg;

    // Default significand geometry: W = SigWidth + LowExpand + 4.
    localparam int unsigned SigWidth  = 4;
    localparam int unsigned LowExpand = 2;
    localparam int unsigned Chunk     = 2;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    localparam int unsigned W         = SigWidth + LowExpand + 4;
    localparam int unsigned NCHUNK    = ceil_div(W, Chunk);
    localparam int unsigned ChunkIdxW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSub  = 2'd1,
        StNeg  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/sig_subtractor_seq_sub_chunk.sv
// One chunk of the ripple chain: Width adder_1bit cells (a, b_eff, cin -> s, cout).
// cout_top exposes the carry out of bit TopBit so a zero-padded top chunk can take
// its carry from the last real bit instead of from the pad.
module sig_subtractor_seq_sub_chunk #(
    parameter int unsigned Width  = 2,
    parameter int unsigned TopBit = Width - 1
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             cin,
    output logic [Width-1:0] s,
    output logic             cout,
    output logic             cout_top
);

    logic [Width:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < Width; i++) begin : g_cell
        // Full-adder cell.
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout     = c[Width];
    assign cout_top = c[TopBit+1];

endmodule

// File: rtl/sig_subtractor_seq.sv
// Multi-cycle unsigned subtractor: a - b = a + ~b + 1, CHUNK bits per cycle, LSB first.
// A negative result is turned into |a-b| by a second pass computing ~diff + 1 on the same chain.
module sig_subtractor_seq
    import sig_subtractor_seq_pkg::*;
#(
    parameter int unsigned sigWidth   = SigWidth,
    parameter int unsigned low_expand = LowExpand,
    parameter int unsigned CHUNK      = Chunk,
    localparam int unsigned DataW     = sigWidth + low_expand + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DataW-1:0] a,
    input  logic [DataW-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DataW-1:0] diff,
    output logic [DataW-1:0] mag,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned NChunk = ceil_div(DataW, CHUNK);
    localparam int unsigned PadW   = NChunk * CHUNK;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
    // Position of bit DataW-1 inside the top chunk.
    localparam int unsigned TopBit = (DataW - 1) % CHUNK;
    localparam logic [PadW-1:0] MaskExt = PadW'({DataW{1'b1}});

    state_e           state_q, state_d;
    logic [IdxW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [DataW-1:0] a_q, a_d;
    logic [DataW-1:0] b_q, b_d;       // holds b_eff: ~b during SUB, zero during NEG
    logic [DataW-1:0] res_q, res_d;
    logic             zacc_q, zacc_d;
    logic [DataW-1:0] diff_q, diff_d;
    logic [DataW-1:0] mag_q, mag_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic [PadW-1:0]  a_ext, b_ext;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum, chunk_mask;
    logic             cout, cout_top, chain_cout, last;
    logic [DataW-1:0] res_new;
    int unsigned      shamt;

    // Chunk selection; pad bits above DataW read as zero for both a and b_eff.
    assign shamt      = cnt_q * CHUNK;
    assign a_ext      = PadW'(a_q);
    assign b_ext      = PadW'(b_q);
    assign a_chunk    = CHUNK'(a_ext >> shamt);
    assign b_chunk    = CHUNK'(b_ext >> shamt);
    assign chunk_mask = CHUNK'(MaskExt >> shamt);
    assign last       = (cnt_q == IdxW'(NChunk - 1));
    assign chain_cout = last ? cout_top : cout;
    assign res_new    = res_q | DataW'(PadW'(sum) << shamt);

    sig_subtractor_seq_sub_chunk #(
        .Width  (CHUNK),
        .TopBit (TopBit)
    ) u_sub_chunk (
        .a        (a_chunk),
        .b        (b_chunk),
        .cin      (carry_q),
        .s        (sum),
        .cout     (cout),
        .cout_top (cout_top)
    );

    // FSM next-state, datapath next-state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        zacc_d   = zacc_q;
        diff_d   = diff_q;
        mag_d    = mag_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        in_ready = (state_q == StIdle) && !rst;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = ~b;
                    res_d   = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = StSub;
                end
            end
            StSub, StNeg: begin
                res_d   = res_new;
                carry_d = chain_cout;
                cnt_d   = cnt_q + IdxW'(1);
                zacc_d  = zacc_q & ((sum & chunk_mask) == '0);
                if (last) begin
                    if (state_q == StNeg) begin
                        mag_d   = res_new;
                        state_d = StDone;
                    end else if (!chain_cout) begin
                        // a < b: second pass computes ~diff + 1.
                        diff_d   = res_new;
                        borrow_d = 1'b1;
                        zero_d   = 1'b0;
                        a_d      = ~res_new;
                        b_d      = '0;
                        res_d    = '0;
                        carry_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = StNeg;
                    end else begin
                        diff_d   = res_new;
                        mag_d    = res_new;
                        borrow_d = 1'b0;
                        zero_d   = zacc_d;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            zacc_q   <= 1'b0;
            diff_q   <= '0;
            mag_q    <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            zacc_q   <= zacc_d;
            diff_q   <= diff_d;
            mag_q    <= mag_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign mag       = mag_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_sig_subtractor_seq.sv
// Directed and random checks of sig_subtractor_seq at CHUNK=2 (W=10) and CHUNK=3 (padded top chunk).
module tb_sig_subtractor_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, borrow, zero;
    logic [9:0] a = '0, b = '0, diff, mag;

    logic       in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1, borrow3, zero3;
    logic [9:0] a3 = '0, b3 = '0, diff3, mag3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sig_subtractor_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .mag       (mag),
        .borrow    (borrow),
        .zero      (zero)
    );

    sig_subtractor_seq #(
        .sigWidth   (4),
        .low_expand (2),
        .CHUNK      (3)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .a         (a3),
        .b         (b3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .diff      (diff3),
        .mag       (mag3),
        .borrow    (borrow3),
        .zero      (zero3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for in_ready, capture on the next edge, then scramble a/b.
    task automatic start_op(input logic [9:0] av, input logic [9:0] bv);
        int k = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) check("start_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = 10'($urandom);
        b = 10'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    // Full transaction on the CHUNK=2 instance with out_ready=1; lat counts edges after capture.
    task automatic do_op(input string tag, input logic [9:0] av, input logic [9:0] bv,
                         input logic [9:0] ediff, input logic [9:0] emag,
                         input logic eborrow, input logic ezero, input int elat);
        int lat;
        start_op(av, bv);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_diff"}, 32'(diff), 32'(ediff));
        check({tag, "_mag"}, 32'(mag), 32'(emag));
        check({tag, "_borrow"}, 32'(borrow), 32'(eborrow));
        check({tag, "_zero"}, 32'(zero), 32'(ezero));
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    // CHUNK=3 instance against a golden a-b model; NCHUNK=4.
    task automatic op3(input logic [9:0] av, input logic [9:0] bv);
        int k = 0;
        int lat = 0;
        logic [9:0] ed, em;
        logic eb;
        eb = (av < bv);
        ed = av - bv;
        em = eb ? (bv - av) : (av - bv);
        a3 = av;
        b3 = bv;
        in_valid3 = 1'b1;
        while (!in_ready3 && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready3) check("c3_start_ready", 32'(in_ready3), 32'd1);
        tick();
        in_valid3 = 1'b0;
        a3 = 10'($urandom);
        b3 = 10'($urandom);
        do begin
            tick();
            lat++;
        end while (!out_valid3 && lat < 40);
        check("c3_lat", 32'(lat), eb ? 32'd8 : 32'd4);
        check("c3_diff", 32'(diff3), 32'(ed));
        check("c3_mag", 32'(mag3), 32'(em));
        check("c3_borrow", 32'(borrow3), 32'(eb));
        check("c3_zero", 32'(zero3), 32'(av == bv));
    endtask

    initial begin
        bit seen_valid;
        logic [9:0] ra, rb;

        // Reset state.
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_mag", 32'(mag), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, CHUNK=2: no-borrow latency 5 edges, borrow latency 10 edges.
        do_op("t1", 10'h2A5, 10'h0F3, 10'h1B2, 10'h1B2, 1'b0, 1'b0, 5);
        do_op("t2", 10'h005, 10'h009, 10'h3FC, 10'h004, 1'b1, 1'b0, 10);
        do_op("t3eq", 10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b0, 1'b1, 5);
        do_op("t3max", 10'h000, 10'h3FF, 10'h001, 10'h3FF, 1'b1, 1'b0, 10);

        // Backpressure: result held, new in_valid ignored.
        out_ready = 1'b0;
        begin
            int lat;
            start_op(10'h123, 10'h045);
            wait_done(lat);
            check("t4_lat", 32'(lat), 32'd5);
        end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            a = 10'($urandom);
            b = 10'($urandom);
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_diff", 32'(diff), 32'h0DE);
            check("t4_hold_mag", 32'(mag), 32'h0DE);
            check("t4_hold_borrow", 32'(borrow), 32'd0);
            check("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_accept_valid", 32'(out_valid), 32'd0);
        check("t4_accept_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a borrow operation.
        start_op(10'h005, 10'h009);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_diff", 32'(diff), 32'd0);
        check("t5_mag", 32'(mag), 32'd0);
        check("t5_borrow", 32'(borrow), 32'd0);
        check("t5_zero", 32'(zero), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("t5_no_partial", 32'(seen_valid), 32'd0);
        do_op("t5_recover", 10'h3FF, 10'h001, 10'h3FE, 10'h3FE, 1'b0, 1'b0, 5);

        // CHUNK=3: edge cases then random operands against a-b.
        op3(10'h000, 10'h3FF);
        op3(10'h3FF, 10'h000);
        op3(10'h200, 10'h200);
        op3(10'h200, 10'h1FF);
        for (int i = 0; i < 2000; i++) begin
            ra = 10'($urandom);
            rb = (i % 16 == 0) ? ra : 10'($urandom);
            op3(ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
